// File: rtl/fp_cust_arbiter_if.sv
// fp_cust_arbiter_if
// Bundles the two requester custom-instruction ports, the shared FP unit port
// and the error flags of fp_cust_arbiter.
//   rq0_* / rq1_* : dataa, datab, n, start  (requester -> arbiter)
//                   done, result            (arbiter -> requester)
//   fp_*          : dataa, datab, n, start, clk_en (arbiter -> FP unit)
//                   done, result                   (FP unit -> arbiter)
//   err_overrun   : sticky flag, start seen while that requester was pending
//   err_timeout   : sticky watchdog flag, present only with FP_ARB_TIMEOUT_EN
// Modports: slave = the arbiter, master = its environment (requesters + FP unit).
interface fp_cust_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);
  logic [DATA_W-1:0] rq0_dataa;
  logic [DATA_W-1:0] rq0_datab;
  logic [OP_W-1:0]   rq0_n;
  logic              rq0_start;
  logic              rq0_done;
  logic [DATA_W-1:0] rq0_result;

  logic [DATA_W-1:0] rq1_dataa;
  logic [DATA_W-1:0] rq1_datab;
  logic [OP_W-1:0]   rq1_n;
  logic              rq1_start;
  logic              rq1_done;
  logic [DATA_W-1:0] rq1_result;

  logic [DATA_W-1:0] fp_dataa;
  logic [DATA_W-1:0] fp_datab;
  logic [OP_W-1:0]   fp_n;
  logic              fp_start;
  logic              fp_clk_en;
  logic              fp_done;
  logic [DATA_W-1:0] fp_result;

  logic              err_overrun;
`ifdef FP_ARB_TIMEOUT_EN
  logic              err_timeout;
`endif

  modport slave (
    input  rq0_dataa, rq0_datab, rq0_n, rq0_start,
    output rq0_done, rq0_result,
    input  rq1_dataa, rq1_datab, rq1_n, rq1_start,
    output rq1_done, rq1_result,
    output fp_dataa, fp_datab, fp_n, fp_start, fp_clk_en,
    input  fp_done, fp_result,
    output err_overrun
`ifdef FP_ARB_TIMEOUT_EN
    , output err_timeout
`endif
  );

  modport master (
    output rq0_dataa, rq0_datab, rq0_n, rq0_start,
    input  rq0_done, rq0_result,
    output rq1_dataa, rq1_datab, rq1_n, rq1_start,
    input  rq1_done, rq1_result,
    input  fp_dataa, fp_datab, fp_n, fp_start, fp_clk_en,
    output fp_done, fp_result,
    input  err_overrun
`ifdef FP_ARB_TIMEOUT_EN
    , input err_timeout
`endif
  );
endinterface

// File: rtl/fp_cust_arbiter.sv
// fp_cust_arbiter
// Shares one start/done floating-point custom-instruction unit between two
// requesters. Each request (dataa, datab, n) is captured into a per-requester
// holding register, requests are granted round-robin, one operation at a time
// is issued to the FP unit and its result is returned as a one-cycle done pulse.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      fp_cust_arbiter_if.slave: rq0_*/rq1_* requester ports, fp_* FP
//            unit port, err_overrun (and err_timeout when enabled)
// Optional feature: define FP_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYCLES cycles that answers with a quiet NaN and sets err_timeout.
module fp_cust_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
`ifdef FP_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 31
`endif
) (
  input logic              clk,
  input logic              reset_n,
  fp_cust_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [1:0]        pending_reg;
  logic              last_grant_reg;
  logic              grant_reg;
  logic [DATA_W-1:0] hold_a_reg [2];
  logic [DATA_W-1:0] hold_b_reg [2];
  logic [OP_W-1:0]   hold_n_reg [2];
  logic [DATA_W-1:0] result_reg [2];
  logic [1:0]        done_reg;
  logic              fp_start_reg;
  logic [DATA_W-1:0] fp_a_reg;
  logic [DATA_W-1:0] fp_b_reg;
  logic [OP_W-1:0]   fp_n_reg;
  logic              err_overrun_reg;
`ifdef FP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     tmo_cnt_reg;
  logic              err_timeout_reg;
`endif

  logic [DATA_W-1:0] in_a [2];
  logic [DATA_W-1:0] in_b [2];
  logic [OP_W-1:0]   in_n [2];
  logic [1:0]        start;
  logic [1:0]        cap;
  logic [1:0]        pend_base;
  logic [1:0]        pend_next;
  logic              pick;

  always_comb begin
    in_a[0] = bus.rq0_dataa;
    in_b[0] = bus.rq0_datab;
    in_n[0] = bus.rq0_n;
    in_a[1] = bus.rq1_dataa;
    in_b[1] = bus.rq1_datab;
    in_n[1] = bus.rq1_n;
    start   = {bus.rq1_start, bus.rq0_start};
  end

  // A start is only accepted when that requester has nothing pending; the
  // granted requester's pending bit is still set during RESP, so a start in
  // its own RESP cycle is an overrun.
  // The IDLE arbitration is also evaluated in RESP (with the finishing
  // requester removed) so a waiting requester issues in the very next cycle.
  // Fresh captures count as pending immediately, which gives fp_start one
  // cycle after the start pulse when the arbiter is idle.
  always_comb begin
    cap       = start & ~pending_reg;
    pend_base = pending_reg;
    if (state_reg == RESP) begin
      pend_base[grant_reg] = 1'b0;
    end
    pend_next = pend_base | cap;
    pick      = (pend_next == 2'b11) ? ~last_grant_reg : pend_next[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      last_grant_reg  <= 1'b1;
      grant_reg       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        hold_a_reg[i] <= '0;
        hold_b_reg[i] <= '0;
        hold_n_reg[i] <= '0;
        result_reg[i] <= '0;
      end
      done_reg        <= '0;
      fp_start_reg    <= 1'b0;
      fp_a_reg        <= '0;
      fp_b_reg        <= '0;
      fp_n_reg        <= '0;
      err_overrun_reg <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      err_timeout_reg <= 1'b0;
`endif
    end else begin
      done_reg     <= '0;
      fp_start_reg <= 1'b0;
      pending_reg  <= pend_next;
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          hold_a_reg[i] <= in_a[i];
          hold_b_reg[i] <= in_b[i];
          hold_n_reg[i] <= in_n[i];
        end
      end
      if (|(start & pending_reg)) begin
        err_overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE, RESP: begin
          if (|pend_next) begin
            grant_reg      <= pick;
            last_grant_reg <= pick;
            fp_start_reg   <= 1'b1;
            // A request captured this very cycle is not in its holding
            // register yet, so take the operands straight from the port.
            fp_a_reg       <= cap[pick] ? in_a[pick] : hold_a_reg[pick];
            fp_b_reg       <= cap[pick] ? in_b[pick] : hold_b_reg[pick];
            fp_n_reg       <= cap[pick] ? in_n[pick] : hold_n_reg[pick];
            state_reg      <= ISSUE;
          end else begin
            state_reg      <= IDLE;
          end
        end
        ISSUE: begin
          // fp_done is stale during the issue cycle and is not looked at.
          state_reg <= WAIT;
`ifdef FP_ARB_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
        end
        WAIT: begin
          if (bus.fp_done) begin
            result_reg[grant_reg] <= bus.fp_result;
            done_reg[grant_reg]   <= 1'b1;
            state_reg             <= RESP;
          end
`ifdef FP_ARB_TIMEOUT_EN
          else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            result_reg[grant_reg] <= DATA_W'(32'h7FC0_0000);
            done_reg[grant_reg]   <= 1'b1;
            err_timeout_reg       <= 1'b1;
            state_reg             <= RESP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rq0_done    = done_reg[0];
  assign bus.rq0_result  = result_reg[0];
  assign bus.rq1_done    = done_reg[1];
  assign bus.rq1_result  = result_reg[1];
  assign bus.fp_dataa    = fp_a_reg;
  assign bus.fp_datab    = fp_b_reg;
  assign bus.fp_n        = fp_n_reg;
  assign bus.fp_start    = fp_start_reg;
  assign bus.fp_clk_en   = 1'b1;
  assign bus.err_overrun = err_overrun_reg;
`ifdef FP_ARB_TIMEOUT_EN
  assign bus.err_timeout = err_timeout_reg;
`endif
endmodule

// File: tb/tb_fp_cust_arbiter.sv
// tb_fp_cust_arbiter
// Self-checking bench for fp_cust_arbiter: a behavioural FP unit model
// (fixed latency per opcode, optional stale done), a table of single
// requests, hand-written multi-cycle sequences and a randomized run scored
// against per-requester expected-result queues.
module tb_fp_cust_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 2;
  localparam logic [31:0] OP3_RES = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fp_cust_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  fp_cust_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- float helpers (normal numbers only) ----------------
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // ---------------- FP unit model ----------------
  function automatic int fp_lat(input logic [1:0] n);
    case (n)
      2'd0: return 7;
      2'd1: return 7;
      2'd2: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] n);
    case (n)
      2'd0: return r2sp(sp2r(a) + sp2r(b));
      2'd1: return r2sp(sp2r(a) - sp2r(b));
      2'd2: return r2sp(sp2r(a) * sp2r(b));
      default: return OP3_RES;
    endcase
  endfunction

  logic        m_busy = 1'b0;
  int          m_due = 0;
  logic [31:0] m_res = 32'd0;
  logic        stale = 1'b0;
  logic        never = 1'b0;

  always @(posedge clk) begin
    if (m_busy && cyc == m_due) m_busy <= 1'b0;
    if (bus.fp_start) begin
      m_busy <= 1'b1;
      m_due  <= cyc + fp_lat(bus.fp_n);
      m_res  <= fp_calc(bus.fp_dataa, bus.fp_datab, bus.fp_n);
    end
  end
  assign bus.fp_done   = m_busy ? (cyc == m_due && !never) : stale;
  assign bus.fp_result = m_res;

  // ---------------- monitor (mid-cycle sampling) ----------------
  int          done0_cyc[$];
  logic [31:0] done0_res[$];
  int          done1_cyc[$];
  logic [31:0] done1_res[$];
  int          order[$];
  int          start_cyc[$];
  logic [31:0] start_a[$];
  logic [1:0]  start_n[$];
  int          mon_anom = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rq0_done) begin
        done0_cyc.push_back(cyc); done0_res.push_back(bus.rq0_result); order.push_back(0);
      end
      if (bus.rq1_done) begin
        done1_cyc.push_back(cyc); done1_res.push_back(bus.rq1_result); order.push_back(1);
      end
      if (bus.rq0_done && bus.rq1_done) mon_anom <= mon_anom + 1;
      if (bus.fp_start) begin
        start_cyc.push_back(cyc); start_a.push_back(bus.fp_dataa); start_n.push_back(bus.fp_n);
        if (m_busy) mon_anom <= mon_anom + 1;
      end
    end
  end

  // ---------------- utilities ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    done0_cyc.delete(); done0_res.delete(); done1_cyc.delete(); done1_res.delete();
    order.delete(); start_cyc.delete(); start_a.delete(); start_n.delete();
  endtask

  task automatic clr_start();
    bus.rq0_start = 1'b0;
    bus.rq1_start = 1'b0;
    bus.rq0_dataa = $urandom; bus.rq0_datab = $urandom;
    bus.rq1_dataa = $urandom; bus.rq1_datab = $urandom;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] n);
    if (r == 0) begin
      bus.rq0_dataa = a; bus.rq0_datab = b; bus.rq0_n = n; bus.rq0_start = 1'b1;
    end else begin
      bus.rq1_dataa = a; bus.rq1_datab = b; bus.rq1_n = n; bus.rq1_start = 1'b1;
    end
  endtask

  function automatic int qsize(input int r);
    return (r == 0) ? done0_cyc.size() : done1_cyc.size();
  endfunction

  function automatic int first_cyc(input int r);
    if (qsize(r) == 0) return -1;
    return (r == 0) ? done0_cyc[0] : done1_cyc[0];
  endfunction

  function automatic logic [31:0] first_res(input int r);
    if (qsize(r) == 0) return 32'hFFFF_FFFF;
    return (r == 0) ? done0_res[0] : done1_res[0];
  endfunction

  task automatic wait_done(input int r, input int maxc, input string nm);
    int k = 0;
    while (qsize(r) == 0 && k < maxc) begin
      tick();
      k++;
    end
    if (qsize(r) == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done from rq%0d within %0d cycles (required one)", nm, r, maxc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    clr_start();
    tick();
    tick();
    reset_n = 1'b1;
    clr_logs();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rq0_done"},  32'(bus.rq0_done), 32'd0);
    check({nm, "_rq1_done"},  32'(bus.rq1_done), 32'd0);
    check({nm, "_rq0_res"},   bus.rq0_result, 32'd0);
    check({nm, "_rq1_res"},   bus.rq1_result, 32'd0);
    check({nm, "_fp_start"},  32'(bus.fp_start), 32'd0);
    check({nm, "_fp_dataa"},  bus.fp_dataa, 32'd0);
    check({nm, "_fp_datab"},  bus.fp_datab, 32'd0);
    check({nm, "_fp_n"},      32'(bus.fp_n), 32'd0);
    check({nm, "_fp_clk_en"}, 32'(bus.fp_clk_en), 32'd1);
    check({nm, "_err_ovr"},   32'(bus.err_overrun), 32'd0);
`ifdef FP_ARB_TIMEOUT_EN
    check({nm, "_err_tmo"},   32'(bus.err_timeout), 32'd0);
`endif
  endtask

  function automatic logic [31:0] ref_result(input int ka, input int kb, input logic [1:0] n);
    case (n)
      2'd0: return r2sp(real'(ka + kb));
      2'd1: return r2sp(real'(ka - kb));
      2'd2: return r2sp(real'(ka * kb));
      default: return OP3_RES;
    endcase
  endfunction

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  n;
    logic [31:0] exp;
    int          lat;
    bit          stale;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];

  task automatic score(input int r, inout int don);
    logic [31:0] got, want;
    while (((r == 0) ? done0_res.size() : done1_res.size()) > 0) begin
      got = (r == 0) ? done0_res.pop_front() : done1_res.pop_front();
      if (((r == 0) ? expq0.size() : expq1.size()) == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rand_rq%0d_extra_done: got result %h, required no done", r, got);
      end else begin
        want = (r == 0) ? expq0.pop_front() : expq1.pop_front();
        check($sformatf("rand_rq%0d_result", r), got, want);
      end
      don++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int k;
    int iss[2];
    int don[2];
    int ka, kb;
    logic [1:0] rn;
    logic [31:0] ra, rb;

    vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 2'd0, 32'h4040_0000, 9, 1'b0};
    vecs[1] = '{1, 32'h4000_0000, 32'h4040_0000, 2'd2, 32'h40C0_0000, 7, 1'b1};
    vecs[2] = '{0, 32'h4040_0000, 32'h3F80_0000, 2'd1, 32'h4000_0000, 9, 1'b0};
    vecs[3] = '{1, 32'h3F80_0000, 32'h4040_0000, 2'd1, 32'hC000_0000, 9, 1'b1};
    vecs[4] = '{0, 32'h4040_0000, 32'h4040_0000, 2'd2, 32'h4110_0000, 7, 1'b0};
    vecs[5] = '{1, 32'h4110_0000, 32'h3F80_0000, 2'd0, 32'h4120_0000, 9, 1'b0};
    vecs[6] = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, OP3_RES,      3, 1'b0};

    bus.rq0_n = '0; bus.rq1_n = '0;
    clr_start();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clr_logs();

    // ---- table of single requests ----
    for (int i = 0; i < 7; i++) begin
      stale = vecs[i].stale;
      repeat (3) tick();
      clr_logs();
      t = cyc;
      set_req(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].n);
      tick();
      clr_start();
      wait_done(vecs[i].r, 40, $sformatf("vec%0d_wait", i));
      repeat (2) tick();
      $display("vec %0d: rq%0d op%0d %h,%h -> %h", i, vecs[i].r, vecs[i].n, vecs[i].a, vecs[i].b, first_res(vecs[i].r));
      check($sformatf("vec%0d_result", i), first_res(vecs[i].r), vecs[i].exp);
      check($sformatf("vec%0d_done_lat", i), first_cyc(vecs[i].r) - t, vecs[i].lat);
      check($sformatf("vec%0d_fp_start_lat", i), (start_cyc.size() > 0) ? start_cyc[0] - t : -1, 1);
      check($sformatf("vec%0d_fp_dataa", i), (start_a.size() > 0) ? start_a[0] : 32'hFFFF_FFFF, vecs[i].a);
      check($sformatf("vec%0d_fp_n", i), (start_n.size() > 0) ? 32'(start_n[0]) : 32'hFFFF_FFFF, 32'(vecs[i].n));
      check($sformatf("vec%0d_other_done", i), qsize(1 - vecs[i].r), 0);
    end
    stale = 1'b0;

    // ---- simultaneous starts after reset ----
    do_reset();
    t = cyc;
    set_req(0, 32'h4040_0000, 32'h3F80_0000, 2'd1);
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 2'd0);
    tick();
    clr_start();
    wait_done(1, 60, "simul_wait_rq1");
    $display("simul: rq0 done @%0d res %h, rq1 done @%0d res %h", first_cyc(0) - t, first_res(0), first_cyc(1) - t, first_res(1));
    check("simul_rq0_lat", first_cyc(0) - t, 9);
    check("simul_rq0_res", first_res(0), 32'h4000_0000);
    check("simul_rq1_fp_start", (start_cyc.size() > 1) ? start_cyc[1] - t : -1, 10);
    check("simul_rq1_lat", first_cyc(1) - t, 18);
    check("simul_rq1_res", first_res(1), 32'h4000_0000);

    // ---- round-robin fairness, back-to-back re-issue ----
    do_reset();
    iss[0] = 0; iss[1] = 0;
    k = 0;
    while ((done0_cyc.size() + done1_cyc.size()) < 8 && k < 400) begin
      clr_start();
      for (int r = 0; r < 2; r++) begin
        if (iss[r] < 4 && iss[r] == qsize(r)) begin
          set_req(r, 32'h3F80_0000, 32'h4000_0000, 2'(r * 2));
          iss[r]++;
        end
      end
      tick();
      k++;
    end
    clr_start();
    check("rr_count", order.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_grant%0d", i), (order.size() > i) ? order[i] : -1, i % 2);
    end
    check("rr_err_overrun", 32'(bus.err_overrun), 32'd0);

    // ---- overrun ----
    do_reset();
    t = cyc;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 2'd0);
    tick();
    clr_start();
    tick();
    tick();
    set_req(0, 32'h4120_0000, 32'h4120_0000, 2'd2);
    tick();
    clr_start();
    check("ovr_flag", 32'(bus.err_overrun), 32'd1);
    wait_done(0, 40, "ovr_wait");
    repeat (20) tick();
    check("ovr_result", first_res(0), 32'h4040_0000);
    check("ovr_lat", first_cyc(0) - t, 9);
    check("ovr_single_done", qsize(0), 1);
    check("ovr_single_issue", start_cyc.size(), 1);
    check("ovr_sticky", 32'(bus.err_overrun), 32'd1);

    // ---- reset in the middle of WAIT ----
    do_reset();
    t = cyc;
    set_req(1, 32'h3F80_0000, 32'h4000_0000, 2'd0);
    tick();
    clr_start();
    repeat (3) tick();
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    check("midrst_no_done", qsize(0) + qsize(1), 0);
    clr_logs();
    t = cyc;
    set_req(0, 32'h4000_0000, 32'h4040_0000, 2'd2);
    tick();
    clr_start();
    wait_done(0, 40, "midrst_next_wait");
    check("midrst_next_res", first_res(0), 32'h40C0_0000);
    check("midrst_next_lat", first_cyc(0) - t, 7);

    // ---- randomized traffic against expected-result queues ----
    do_reset();
    expq0.delete(); expq1.delete();
    iss[0] = 0; iss[1] = 0; don[0] = 0; don[1] = 0;
    k = 0;
    while ((don[0] < 24 || don[1] < 24) && k < 3000) begin
      score(0, don[0]);
      score(1, don[1]);
      clr_start();
      for (int r = 0; r < 2; r++) begin
        if (iss[r] < 24 && iss[r] == don[r] && $urandom_range(0, 2) == 0) begin
          ka = int'($urandom_range(1, 64));
          kb = int'($urandom_range(1, 64));
          rn = 2'($urandom_range(0, 3));
          ra = r2sp(real'(ka));
          rb = r2sp(real'(kb));
          set_req(r, ra, rb, rn);
          if (r == 0) expq0.push_back(ref_result(ka, kb, rn));
          else        expq1.push_back(ref_result(ka, kb, rn));
          iss[r]++;
          $display("rand: rq%0d op%0d %0d,%0d", r, rn, ka, kb);
        end
      end
      tick();
      k++;
    end
    clr_start();
    check("rand_rq0_count", don[0], 24);
    check("rand_rq1_count", don[1], 24);
    check("rand_err_overrun", 32'(bus.err_overrun), 32'd0);

`ifdef FP_ARB_TIMEOUT_EN
    // ---- watchdog: FP unit never answers ----
    do_reset();
    never = 1'b1;
    t = cyc;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 2'd0);
    tick();
    clr_start();
    wait_done(0, 60, "tmo_wait");
    check("tmo_lat", first_cyc(0) - t, 33);
    check("tmo_result", first_res(0), 32'h7FC0_0000);
    check("tmo_flag", 32'(bus.err_timeout), 32'd1);
    never = 1'b0;
`endif

    check("monitor_anomalies", mon_anom, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_cust_arbiter.md
Name: fp_cust_arbiter

Overview:
- Shares one floating-point custom-instruction unit (add/sub/mul, start/done handshake, fixed per-opcode latency) between two requesters, e.g. two Nios custom-instruction masters.
- Each requester sees a standard multi-cycle custom-instruction slave: one-cycle start, later a one-cycle done with the result.
- The block captures requests, round-robin arbitrates, issues exactly one operation at a time to the FP unit and routes the result back.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 2, opcode (n) width; 0=add, 1=sub, 2=mul, 3=reserved.
- TIMEOUT_CYCLES, 31, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rq0_dataa, rq0_datab  in  DATA_W  requester 0 operands.
- rq0_n  in  OP_W  requester 0 opcode.
- rq0_start  in  1  requester 0 start pulse.
- rq0_done  out  1  requester 0 done pulse.
- rq0_result  out  DATA_W  requester 0 result, valid with rq0_done.
- rq1_*  same six signals for requester 1.
- fp_dataa, fp_datab  out  DATA_W  operands to the FP unit.
- fp_n  out  OP_W  opcode to the FP unit.
- fp_start  out  1  start to the FP unit.
- fp_clk_en  out  1  clock enable to the FP unit.
- fp_done  in  1  FP unit done.
- fp_result  in  DATA_W  FP unit result.
- err_overrun  out  1  sticky flag: start seen while that requester was already pending.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; pending[1:0]=0; holding registers=0.
  - All outputs 0, except fp_clk_en=1.
  - last_grant=1, so requester 0 wins the first tie.
- Capture: rqX_start=1 with pending[X]=0 latches dataa/datab/n into holding register X and sets pending[X] next cycle. This happens in any state, so capture during another requester's operation is legal.
- Overrun: rqX_start=1 with pending[X]=1 is dropped (holding register unchanged) and sets err_overrun. err_overrun clears only on reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any pending bit is set, grant moves to ISSUE.
    - One pending: grant it.
    - Both pending: grant the one that is not last_grant.
    - Update last_grant.
  - ISSUE (1 cycle): fp_start=1; fp_dataa/fp_datab/fp_n driven from the granted holding register. Go to WAIT.
  - WAIT:
    - fp_start=0; fp_dataa/datab/n held stable.
    - fp_done is ignored in the ISSUE cycle itself. The FP unit's done is stale while idle and asserts spuriously.
    - The first fp_done=1 in WAIT registers fp_result into rqG_result and goes to RESP.
  - RESP (1 cycle): rqG_done=1; clear pending[G]; go to IDLE.
    - The non-granted done output stays 0.
    - rqG_result holds its value until that requester's next done.
- Latency: a request captured at cycle t into an idle arbiter gives fp_start at t+1, fp_done at t+1+L, and rqX_done at t+2+L. For add (L=7) that is t+9; for mul (L=5) it is t+7.
- Simultaneous starts at cycle t:
  - Both are captured.
  - The round-robin winner is issued first.
  - The loser issues from IDLE the cycle after the winner's RESP, with no lost request.
- Opcode 3: passed through unchanged. The FP unit reports done after one cycle, and the result is whatever fp_result holds. Requesters must not rely on it.
- fp_clk_en is constant 1. The FP unit is never stalled.
- rqX_start arriving in the same cycle as that requester's RESP: pending is still 1, so the start is an overrun and is dropped.
- Reset mid-operation: everything returns to reset values immediately. An in-flight FP result is discarded, and no done pulse is emitted.

Optional Feature:
- Macro: FP_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears in ISSUE and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without fp_done, go to RESP with rqG_result=32'h7FC0_0000 (quiet NaN) and set sticky output err_timeout (extra port, 1 bit, reset 0).
- Undefined: no counter and no err_timeout port; WAIT lasts until fp_done.

Test Plan:
- Single add: rq0 start, dataa=3F800000, datab=40000000, n=0 at t -> fp_start at t+1, rq0_done at t+9, rq0_result=40400000; rq1_done stays 0.
- Stale done: FP model holds fp_done=1 while idle; rq1 mul 40000000*40400000 -> done not taken in ISSUE cycle; rq1_done at t+7, result=40C00000.
- Simultaneous starts after reset: rq0 sub 40400000-3F800000, rq1 add at the same cycle -> rq0 served first (result 40000000 at t+9); rq1 fp_start in the cycle after rq0_done.
- Round-robin fairness: both requesters re-issue immediately after each done for 8 operations -> grants alternate 0,1,0,1...; err_overrun stays 0.
- Overrun: rq0 starts again while pending -> err_overrun=1; first request's operands and result unaffected.
- Reset mid-WAIT: reset_n low 3 cycles after fp_start -> all outputs 0, no done; a subsequent request completes normally. With FP_ARB_TIMEOUT_EN and an FP model that never returns done -> rq0_done after 31 WAIT cycles, result 7FC00000, err_timeout=1.
